// File: rtl/router_pkt_reader.sv
// Drains one router output port: issues FIFO reads, rebuilds each packet,
// streams its payload to the sink and checks length/parity and service latency.
module router_pkt_reader #(
   parameter int STALL_LIMIT = 29,
   parameter int GAP_LIMIT   = 64
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       valid_out,
   input  logic [7:0] data_out,
   input  logic       sink_stall,
   output logic       read_enb,
   output logic [7:0] pkt_hdr,
   output logic [7:0] pkt_byte,
   output logic       pkt_byte_vld,
   output logic       pkt_done,
   output logic       parity_err,
   output logic       pkt_abort,
   output logic       timeout_warn,
   output logic       active
);

   localparam int GAP_W = $clog2(GAP_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, HDR_WAIT, STREAM, CHECK} state_t;

   state_t           r_state;
   logic [6:0]       r_rem;
   logic [6:0]       r_issued;
   logic [6:0]       r_rcv;
   logic [4:0]       r_stall;
   logic [GAP_W-1:0] r_gap;
   logic [7:0]       r_par;
   logic             r_rd_p1;

   logic             w_rd_en;
   logic             w_rd_eff;
   logic             w_more;
   logic             w_gap_cyc;
   logic [6:0]       w_rem;

   assign w_more    = (r_issued < r_rem);
   assign w_rem     = {1'b0, data_out[7:2]} + 7'd1;
   assign w_gap_cyc = !valid_out && w_more;

   always_comb begin
      w_rd_en = 1'b0;
      case (r_state)
         IDLE:    w_rd_en = valid_out & ~sink_stall;
         STREAM:  w_rd_en = valid_out & w_more;
         default: w_rd_en = 1'b0;
      endcase
   end

   // Held low during reset so no byte is pulled from the router and then lost.
   assign read_enb = resetn & w_rd_en;
   assign w_rd_eff = read_enb & valid_out;
   assign active   = (r_state != IDLE);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_rem        <= '0;
         r_issued     <= '0;
         r_rcv        <= '0;
         r_stall      <= '0;
         r_gap        <= '0;
         r_par        <= '0;
         r_rd_p1      <= 1'b0;
         pkt_hdr      <= '0;
         pkt_byte     <= '0;
         pkt_byte_vld <= 1'b0;
         pkt_done     <= 1'b0;
         parity_err   <= 1'b0;
         pkt_abort    <= 1'b0;
         timeout_warn <= 1'b0;
      end else begin
         pkt_byte_vld <= 1'b0;
         pkt_done     <= 1'b0;
         parity_err   <= 1'b0;
         pkt_abort    <= 1'b0;
         timeout_warn <= 1'b0;
         // p0 -> p1: remember which cycles launched a read; data lands one cycle later
         r_rd_p1      <= w_rd_eff;

         // Stall watch saturates at the limit so the warning fires once per episode.
         if (r_state == IDLE && valid_out && sink_stall) begin
            if (r_stall != 5'(STALL_LIMIT)) begin
               r_stall <= r_stall + 5'd1;
               if (r_stall == 5'(STALL_LIMIT - 1))
                  timeout_warn <= 1'b1;
            end
         end else begin
            r_stall <= '0;
         end

         case (r_state)
            IDLE: begin
               if (w_rd_eff)
                  r_state <= HDR_WAIT;
            end
            HDR_WAIT: begin
               pkt_hdr  <= data_out;
               r_par    <= data_out;
               r_rem    <= w_rem;
               r_rcv    <= w_rem;
               r_issued <= '0;
               r_gap    <= '0;
               r_state  <= STREAM;
            end
            STREAM: begin
               if (w_rd_eff) begin
                  r_issued <= r_issued + 7'd1;
                  r_gap    <= '0;
               end else if (w_gap_cyc) begin
                  r_gap <= r_gap + GAP_W'(1);
               end
               // p1 -> p2: returning byte is either payload or the trailing parity byte
               if (r_rd_p1) begin
                  r_rcv <= r_rcv - 7'd1;
                  if (r_rcv > 7'd1) begin
                     r_par        <= r_par ^ data_out;
                     pkt_byte     <= data_out;
                     pkt_byte_vld <= 1'b1;
                  end else begin
                     pkt_done   <= 1'b1;
                     parity_err <= (r_par != data_out);
                     r_state    <= CHECK;
                  end
               end else if (w_gap_cyc && r_gap == GAP_W'(GAP_LIMIT - 1)) begin
                  pkt_abort <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            CHECK: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader: a packet table run through a FIFO
// model, plus hand sequences for stall warning, gap abort and mid-packet reset.
module tb_router_pkt_reader;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       valid_out = 1'b0;
   logic [7:0] data_out = 8'h00;
   logic       sink_stall = 1'b0;
   logic       read_enb;
   logic [7:0] pkt_hdr;
   logic [7:0] pkt_byte;
   logic       pkt_byte_vld;
   logic       pkt_done;
   logic       parity_err;
   logic       pkt_abort;
   logic       timeout_warn;
   logic       active;

   router_pkt_reader #(.STALL_LIMIT(29), .GAP_LIMIT(64)) dut (
      .clock(clock), .resetn(resetn), .valid_out(valid_out), .data_out(data_out),
      .sink_stall(sink_stall), .read_enb(read_enb), .pkt_hdr(pkt_hdr),
      .pkt_byte(pkt_byte), .pkt_byte_vld(pkt_byte_vld), .pkt_done(pkt_done),
      .parity_err(parity_err), .pkt_abort(pkt_abort), .timeout_warn(timeout_warn),
      .active(active)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  hdr;
      logic [63:0] pay;
      logic [7:0]  par;
      int          gap_after;
      int          gap_len;
      logic        exp_err;
      logic        trace_on;
      logic [7:0]  exp_re;
      logic [7:0]  exp_vld;
      logic [7:0]  exp_done;
   } vec_t;

   vec_t       vecs[7];
   logic [7:0] fifo[$];
   logic [7:0] got[$];
   int         checks = 0;
   int         errors = 0;
   int         nreads, ndone, nabort, nwarn, nviol, cyc, gap_left, gap_after_g;
   int         last_eff_cyc, abort_cyc, warn_idx;
   logic       last_err, last_eff, gate, stall_d, rstn_d;
   logic [7:0] re_tr, vld_tr, done_tr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clr_logs();
      nreads = 0; ndone = 0; nabort = 0; nwarn = 0; cyc = 0;
      last_err = 1'b0; re_tr = '0; vld_tr = '0; done_tr = '0;
      last_eff_cyc = -1; abort_cyc = -1; warn_idx = -1;
      got.delete();
   endtask

   // Inputs change just after the rising edge; outputs are observed on the falling edge.
   task automatic step();
      logic eff;
      @(posedge clock);
      #1;
      resetn     = rstn_d;
      sink_stall = stall_d;
      if (last_eff && fifo.size() > 0) data_out = fifo.pop_front();
      if (gap_left > 0 && nreads == gap_after_g) begin
         gate = 1'b0;
         gap_left--;
      end else begin
         gate = 1'b1;
      end
      valid_out = gate && (fifo.size() > 0);
      @(negedge clock);
      eff = read_enb & valid_out;
      if (eff) begin
         nreads++;
         last_eff_cyc = cyc;
      end
      if (read_enb && !valid_out) nviol++;
      if (pkt_done && (read_enb || pkt_abort)) nviol++;
      if (pkt_byte_vld) got.push_back(pkt_byte);
      if (pkt_done) begin
         ndone++;
         last_err = parity_err;
      end
      if (pkt_abort) begin
         nabort++;
         abort_cyc = cyc;
      end
      if (timeout_warn) begin
         nwarn++;
         warn_idx = cyc;
      end
      if (cyc < 8) begin
         re_tr   = {re_tr[6:0], read_enb};
         vld_tr  = {vld_tr[6:0], pkt_byte_vld};
         done_tr = {done_tr[6:0], pkt_done};
      end
      cyc++;
      last_eff = eff;
   endtask

   task automatic run_pkt(input vec_t v);
      int len;
      len = int'(v.hdr[7:2]);
      fifo.push_back(v.hdr);
      for (int k = 0; k < len; k++) fifo.push_back(v.pay[63-8*k -: 8]);
      fifo.push_back(v.par);
      clr_logs();
      gap_after_g = v.gap_after;
      gap_left    = v.gap_len;
      for (int c = 0; c < 200; c++) begin
         step();
         if (ndone > 0 || nabort > 0) break;
      end
      step();
      chk("active_after_done", active, 1'b0);
      while (cyc < 10) step();
      chk("done_count", ndone, 1);
      chk("parity_err", last_err, v.exp_err);
      chk("abort_count", nabort, 0);
      chk("eff_reads", nreads, len + 2);
      chk("pkt_hdr", pkt_hdr, v.hdr);
      chk("byte_count", got.size(), len);
      for (int k = 0; k < len && k < got.size(); k++)
         chk("payload_byte", got[k], v.pay[63-8*k -: 8]);
      if (v.trace_on) begin
         chk("read_enb_trace", re_tr, v.exp_re);
         chk("byte_vld_trace", vld_tr, v.exp_vld);
         chk("done_trace", done_tr, v.exp_done);
      end
   endtask

   initial begin
      vecs[0] = '{8'h0D, 64'h1122330000000000, 8'h0D, 0, 0, 1'b0, 1'b1, 8'hBC, 8'h0E, 8'h01};
      vecs[1] = '{8'h0D, 64'h1122330000000000, 8'h00, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{8'h02, 64'h0000000000000000, 8'h02, 0, 0, 1'b0, 1'b1, 8'hA0, 8'h00, 8'h08};
      vecs[3] = '{8'h12, 64'hA1B2C3D400000000, 8'h16, 2, 5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[4] = '{8'h1F, 64'h0102040810204000, 8'h60, 0, 0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[5] = '{8'h1F, 64'h0102040810204000, 8'h61, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[6] = '{8'h0D, 64'h1122330000000000, 8'h2F, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};

      nviol = 0; gap_left = 0; gap_after_g = 0; gate = 1'b1;
      last_eff = 1'b0; stall_d = 1'b0; rstn_d = 1'b0;
      clr_logs();

      // Reset state
      repeat (3) step();
      chk("reset_outputs", {read_enb, pkt_hdr, pkt_byte, pkt_byte_vld, pkt_done,
                            parity_err, pkt_abort, timeout_warn, active}, 32'h0);
      rstn_d = 1'b1;
      repeat (2) step();

      // Packet table
      for (int i = 0; i < 7; i++) run_pkt(vecs[i]);

      // Stall watchdog: warn once after 29 stalled cycles, no reads meanwhile
      fifo.push_back(8'h02);
      fifo.push_back(8'h02);
      clr_logs();
      stall_d = 1'b1;
      repeat (35) step();
      chk("warn_count", nwarn, 1);
      chk("warn_cycle", warn_idx, 29);
      chk("reads_while_stalled", nreads, 0);
      stall_d = 1'b0;
      step();
      chk("read_after_release", read_enb, 1'b1);
      for (int c = 0; c < 20 && ndone == 0; c++) step();
      chk("stall_pkt_done", ndone, 1);
      chk("stall_pkt_err", last_err, 1'b0);
      repeat (3) step();

      // Gap abort: len-10 header but only two payload bytes ever arrive
      fifo.push_back(8'h28);
      fifo.push_back(8'h5A);
      fifo.push_back(8'hA5);
      clr_logs();
      for (int c = 0; c < 200 && nabort == 0; c++) step();
      chk("abort_count", nabort, 1);
      chk("abort_active", active, 1'b0);
      chk("abort_latency", abort_cyc - last_eff_cyc, 65);
      chk("abort_no_done", ndone, 0);
      chk("abort_bytes", got.size(), 2);
      if (got.size() == 2) chk("abort_byte1", got[1], 8'hA5);
      step();
      chk("idle_after_abort", active, 1'b0);

      // Mid-packet reset drops the packet silently
      fifo.push_back(8'h28);
      for (int k = 0; k < 11; k++) fifo.push_back(8'(k + 1));
      clr_logs();
      for (int c = 0; c < 60 && got.size() < 2; c++) step();
      chk("pre_reset_bytes", got.size(), 2);
      rstn_d = 1'b0;
      step();
      step();
      chk("midpkt_reset_outputs", {read_enb, pkt_hdr, pkt_byte, pkt_byte_vld, pkt_done,
                                   parity_err, pkt_abort, timeout_warn, active}, 32'h0);
      fifo.delete();
      rstn_d = 1'b1;
      clr_logs();
      repeat (70) step();
      chk("post_reset_no_done", ndone, 0);
      chk("post_reset_no_abort", nabort, 0);

      // Recovery after reset
      run_pkt(vecs[0]);
      chk("protocol_violations", nviol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
